// File: rtl/cascade_time_counter_pkg.sv
// Shared types and default moduli for the stopwatch/countdown timebase.
package stopwatch_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int CS_MAX          = 99;
  localparam int SEC_MAX         = 59;
  localparam int MIN_MAX         = 59;
  localparam int STAGE_W_DEFAULT = 7;

endpackage

// File: rtl/cascade_time_counter_if.sv
// Control/status bundle of the cascaded time counter.
// Lap signals exist only when CASCADE_TIME_COUNTER_LAP_EN is defined.
interface cascade_time_counter_if
  import stopwatch_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int WIDTH  = STAGE_W_DEFAULT
);
  logic                      en;
  dir_e                      dir;
  logic                      clear;
  logic                      load;
  logic [STAGES*WIDTH-1:0]   load_value;
  logic [STAGES*WIDTH-1:0]   value;
  logic                      carry_out;
  logic                      at_zero;
`ifdef CASCADE_TIME_COUNTER_LAP_EN
  logic                      lap_req;
  logic [STAGES*WIDTH-1:0]   lap_value;
  logic                      lap_valid;
`endif

  modport master (
    output en, dir, clear, load, load_value,
`ifdef CASCADE_TIME_COUNTER_LAP_EN
    output lap_req,
    input  lap_value, lap_valid,
`endif
    input  value, carry_out, at_zero
  );

  modport slave (
    input  en, dir, clear, load, load_value,
`ifdef CASCADE_TIME_COUNTER_LAP_EN
    input  lap_req,
    output lap_value, lap_valid,
`endif
    output value, carry_out, at_zero
  );

endinterface

// File: rtl/cascade_time_counter_stage.sv
// One modulo-(MAX_VALUE+1) digit of the cascade. Clear beats load beats step;
// load clamps out-of-range presets to MAX_VALUE so the stage never leaves its range.
module mod_counter_stage
  import stopwatch_pkg::*;
#(
  parameter int               WIDTH     = STAGE_W_DEFAULT,
  parameter logic [WIDTH-1:0] MAX_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  dir_e             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q      = q_q;
  assign at_max = (q_q == MAX_VALUE);
  assign at_min = (q_q == '0);

  // Next digit value: clear, clamped load, or a single up/down step with wrap at this digit.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = (d > MAX_VALUE) ? MAX_VALUE : d;
    end else if (step && !hold) begin
      if (dir == DIR_UP) begin
        q_d = at_max ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = at_min ? MAX_VALUE : q_q - WIDTH'(1);
      end
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/cascade_time_counter.sv
// Cascaded modulo counter chain (e.g. hundredths/seconds/minutes) with synchronous
// carry/borrow lookahead: every stage's step is a prefix AND of the lower stages'
// terminal flags, so all digits update on the same edge without rippling.
// Optional lap capture is enabled by defining CASCADE_TIME_COUNTER_LAP_EN.
module cascade_time_counter
  import stopwatch_pkg::*;
#(
  parameter int                      STAGES     = 3,
  parameter int                      WIDTH      = STAGE_W_DEFAULT,
  parameter logic [STAGES*WIDTH-1:0] MAX_VALUES = {7'(MIN_MAX), 7'(SEC_MAX), 7'(CS_MAX)},
  parameter bit                      WRAP       = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  cascade_time_counter_if.slave bus
);

  logic [STAGES-1:0]       at_max;
  logic [STAGES-1:0]       at_min;
  logic [STAGES-1:0]       step;
  logic [STAGES:0]         all_max_below;
  logic [STAGES:0]         all_min_below;
  logic [STAGES*WIDTH-1:0] value_w;
  logic                    terminal;
  logic                    hold;

  assign all_max_below[0] = 1'b1;
  assign all_min_below[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      assign all_max_below[gi+1] = all_max_below[gi] & at_max[gi];
      assign all_min_below[gi+1] = all_min_below[gi] & at_min[gi];
      assign step[gi] = bus.en &&
                        ((bus.dir == DIR_UP) ? all_max_below[gi] : all_min_below[gi]);

      mod_counter_stage #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUES[gi*WIDTH +: WIDTH])
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .step   (step[gi]),
        .dir    (bus.dir),
        .clear  (bus.clear),
        .load   (bus.load),
        .d      (bus.load_value[gi*WIDTH +: WIDTH]),
        .hold   (hold),
        .q      (value_w[gi*WIDTH +: WIDTH]),
        .at_max (at_max[gi]),
        .at_min (at_min[gi])
      );
    end
  endgenerate

  // Whole chain sits at the terminal value for the current direction.
  assign terminal = (bus.dir == DIR_UP) ? all_max_below[STAGES] : all_min_below[STAGES];
  // In saturating mode the chain freezes at the terminal instead of wrapping.
  assign hold     = !WRAP && terminal;

  assign bus.value     = value_w;
  assign bus.carry_out = bus.en && terminal;
  assign bus.at_zero   = all_min_below[STAGES];

`ifdef CASCADE_TIME_COUNTER_LAP_EN
  logic [STAGES*WIDTH-1:0] lap_value_q;
  logic                    lap_valid_q;

  // Snapshot the pre-update count on lap_req; clear wipes the snapshot and wins over lap_req.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      lap_value_q <= '0;
      lap_valid_q <= 1'b0;
    end else if (bus.lap_req) begin
      lap_value_q <= value_w;
      lap_valid_q <= 1'b1;
    end
  end

  assign bus.lap_value = lap_value_q;
  assign bus.lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_cascade_time_counter.sv
// Directed bench: a WRAP=1 and a WRAP=0 instance receive identical stimulus.
module tb_cascade_time_counter;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cascade_time_counter_if #(.STAGES(3), .WIDTH(7)) bus1 ();
  cascade_time_counter_if #(.STAGES(3), .WIDTH(7)) bus0 ();

  cascade_time_counter #(.WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst), .bus(bus1));
  cascade_time_counter #(.WRAP(1'b0)) u_hold (.clk(clk), .rst(rst), .bus(bus0));

  // {minutes, seconds, hundredths}
  function automatic logic [20:0] pk(input int m, input int s, input int c);
    return {7'(m), 7'(s), 7'(c)};
  endfunction

  typedef struct {
    logic [20:0] pre;
    logic        en;
    dir_e        dir;
    logic        clr;
    logic        ld;
    logic [20:0] ldv;
    logic        c_exp;
    logic [20:0] v_wrap;
    logic [20:0] v_hold;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input dir_e dir, input logic clr,
                        input logic ld, input logic [20:0] ldv);
    bus1.en = en;  bus1.dir = dir; bus1.clear = clr; bus1.load = ld; bus1.load_value = ldv;
    bus0.en = en;  bus0.dir = dir; bus0.clear = clr; bus0.load = ld; bus0.load_value = ldv;
`ifdef CASCADE_TIME_COUNTER_LAP_EN
    bus1.lap_req = 1'b0;
    bus0.lap_req = 1'b0;
`endif
  endtask

  // Drive at negedge, let the edge happen, sample 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [20:0] v);
    @(negedge clk);
    set_in(1'b0, DIR_UP, 1'b0, 1'b1, v);
    cycle();
  endtask

  initial begin
    vecs[0]  = '{pk(0,59,99), 1'b1, DIR_UP,   1'b0, 1'b0, '0,           1'b0, pk(1,0,0),    pk(1,0,0)};
    vecs[1]  = '{pk(59,59,99),1'b1, DIR_UP,   1'b0, 1'b0, '0,           1'b1, pk(0,0,0),    pk(59,59,99)};
    vecs[2]  = '{pk(1,0,0),   1'b1, DIR_DOWN, 1'b0, 1'b0, '0,           1'b0, pk(0,59,99),  pk(0,59,99)};
    vecs[3]  = '{pk(0,0,0),   1'b1, DIR_DOWN, 1'b0, 1'b0, '0,           1'b1, pk(59,59,99), pk(0,0,0)};
    vecs[4]  = '{pk(0,0,0),   1'b0, DIR_UP,   1'b0, 1'b1, pk(70,75,120),1'b0, pk(59,59,99), pk(59,59,99)};
    vecs[5]  = '{pk(1,2,3),   1'b1, DIR_UP,   1'b1, 1'b1, pk(5,5,5),    1'b0, pk(0,0,0),    pk(0,0,0)};
    vecs[6]  = '{pk(0,12,34), 1'b1, DIR_UP,   1'b0, 1'b0, '0,           1'b0, pk(0,12,35),  pk(0,12,35)};
    vecs[7]  = '{pk(0,12,34), 1'b0, DIR_UP,   1'b0, 1'b0, '0,           1'b0, pk(0,12,34),  pk(0,12,34)};
    vecs[8]  = '{pk(5,59,99), 1'b1, DIR_UP,   1'b0, 1'b0, '0,           1'b0, pk(6,0,0),    pk(6,0,0)};
    vecs[9]  = '{pk(5,0,0),   1'b1, DIR_DOWN, 1'b0, 1'b0, '0,           1'b0, pk(4,59,99),  pk(4,59,99)};
    vecs[10] = '{pk(0,0,5),   1'b1, DIR_UP,   1'b0, 1'b1, pk(3,4,5),    1'b0, pk(3,4,5),    pk(3,4,5)};
    vecs[11] = '{pk(59,59,99),1'b0, DIR_UP,   1'b0, 1'b0, '0,           1'b0, pk(59,59,99), pk(59,59,99)};
    vecs[12] = '{pk(59,59,99),1'b1, DIR_DOWN, 1'b0, 1'b0, '0,           1'b0, pk(59,59,98), pk(59,59,98)};
    vecs[13] = '{pk(0,0,0),   1'b1, DIR_UP,   1'b0, 1'b0, '0,           1'b0, pk(0,0,1),    pk(0,0,1)};

    // Reset: value 0, at_zero high, no carry even with en asserted while in reset.
    set_in(1'b1, DIR_UP, 1'b0, 1'b0, '0);
    rst = 1'b1;
    cycle();
    chk("reset_value", bus1.value, '0);
    chk("reset_at_zero", 21'(bus1.at_zero), 21'd1);
    chk("reset_carry", 21'(bus1.carry_out), 21'd0);
`ifdef CASCADE_TIME_COUNTER_LAP_EN
    chk("reset_lap_valid", 21'(bus1.lap_valid), 21'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, DIR_UP, 1'b0, 1'b0, '0);

    for (int i = 0; i < 14; i++) begin
      preload(vecs[i].pre);
      @(negedge clk);
      set_in(vecs[i].en, vecs[i].dir, vecs[i].clr, vecs[i].ld, vecs[i].ldv);
      #1;
      chk($sformatf("v%0d_carry_wrap", i), 21'(bus1.carry_out), 21'(vecs[i].c_exp));
      chk($sformatf("v%0d_carry_hold", i), 21'(bus0.carry_out), 21'(vecs[i].c_exp));
      chk($sformatf("v%0d_at_zero", i), 21'(bus1.at_zero), 21'(vecs[i].pre == '0));
      cycle();
      chk($sformatf("v%0d_value_wrap", i), bus1.value, vecs[i].v_wrap);
      chk($sformatf("v%0d_value_hold", i), bus0.value, vecs[i].v_hold);
      $display("vec %0d pre=%h en=%0b dir=%0d clr=%0b ld=%0b -> wrap=%h hold=%h",
               i, vecs[i].pre, vecs[i].en, vecs[i].dir, vecs[i].clr, vecs[i].ld,
               bus1.value, bus0.value);
    end

    // Back-to-back ticks crossing a seconds and a minutes boundary.
    preload(pk(0,59,98));
    @(negedge clk);
    set_in(1'b1, DIR_UP, 1'b0, 1'b0, '0);
    cycle(); chk("seq_up_1", bus1.value, pk(0,59,99));
    cycle(); chk("seq_up_2", bus1.value, pk(1,0,0));
    cycle(); chk("seq_up_3", bus1.value, pk(1,0,1));
    $display("seq up-run done value=%h", bus1.value);

    // Saturating instance keeps flagging carry on every tick while parked at terminal.
    preload(pk(59,59,99));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(1'b1, DIR_UP, 1'b0, 1'b0, '0);
      #1;
      chk($sformatf("sat_carry_%0d", k), 21'(bus0.carry_out), 21'd1);
      cycle();
      chk($sformatf("sat_value_%0d", k), bus0.value, pk(59,59,99));
    end
    $display("seq saturate done value=%h", bus0.value);

    // Reset in the middle of counting discards the state on the next edge.
    preload(pk(1,2,3));
    @(negedge clk);
    set_in(1'b1, DIR_UP, 1'b0, 1'b0, '0);
    rst = 1'b1;
    cycle();
    chk("midreset_value", bus1.value, '0);
    @(negedge clk);
    rst = 1'b0;
    $display("seq mid-count reset done value=%h", bus1.value);

`ifdef CASCADE_TIME_COUNTER_LAP_EN
    // Lap captures the pre-update count; load leaves it alone; clear wipes it.
    preload(pk(0,12,34));
    @(negedge clk);
    set_in(1'b1, DIR_UP, 1'b0, 1'b0, '0);
    bus1.lap_req = 1'b1;
    bus0.lap_req = 1'b1;
    cycle();
    chk("lap_value", bus1.lap_value, pk(0,12,34));
    chk("lap_valid", 21'(bus1.lap_valid), 21'd1);
    chk("lap_count", bus1.value, pk(0,12,35));
    preload(pk(9,9,9));
    chk("lap_after_load", bus1.lap_value, pk(0,12,34));
    @(negedge clk);
    set_in(1'b0, DIR_UP, 1'b1, 1'b0, '0);
    bus1.lap_req = 1'b1;
    bus0.lap_req = 1'b1;
    cycle();
    chk("lap_clear_valid", 21'(bus1.lap_valid), 21'd0);
    chk("lap_clear_value", bus1.lap_value, '0);
    $display("seq lap done lap_value=%h", bus1.lap_value);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
